// File: rtl/simd_control_unit.sv
// ---------------------------------------------------------------------------
// simd_control_unit
//   Main decoder of the SIMD AES processor decode stage. Turns the opcode,
//   function field and destination register of an instruction into the
//   datapath control word. The decode is combinational. Every control output
//   is registered so that it lines up with the decode/execute pipeline
//   register.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  synchronous active-low reset; clears every output
//   Opcode      in   6  instruction opcode
//   Func        in   3  function field; read only by scalar/vector R-type
//   Rd          in   5  destination register index (11111 aliases the PC)
//   PCSrc       out  1  PC written by this instruction
//   RegWrite    out  1  scalar register-file write
//   RegWriteV   out  1  vector register-file write
//   MemtoReg    out  1  writeback selects memory data
//   MemWrite    out  1  data-memory write
//   MemSrc      out  1  store source: 0 scalar, 1 vector
//   MemData     out  1  scalar memory access
//   MemDataV    out  1  vector memory access
//   VecData     out  1  execute uses vector lanes
//   InstrSel    out  2  00 scalar ALU, 01 vector ALU, 10 memory, 11 control
//   ALUControl  out  3  ALU operation
//   Branch      out  1  branch/jump instruction
//   ALUSrc      out  1  ALU B operand: 0 register, 1 immediate
//   RegSrc      out  2  register-read source select
//   ImmSrc      out  2  00 I-arith, 01 mem offset, 10 branch, 11 jump target
//   ALUOp       out  1  comparison decode active (beq/bgt)
// ---------------------------------------------------------------------------
module simd_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [2:0] Func,
  input  logic [4:0] Rd,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       RegWriteV,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       MemSrc,
  output logic       MemData,
  output logic       MemDataV,
  output logic       VecData,
  output logic [1:0] InstrSel,
  output logic [2:0] ALUControl,
  output logic       Branch,
  output logic       ALUSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ImmSrc,
  output logic       ALUOp
);

  localparam logic [5:0] OP_SCALAR_R = 6'b000000;
  localparam logic [5:0] OP_VECTOR_R = 6'b100000;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_LOAD     = 6'b011001;
  localparam logic [5:0] OP_STORE    = 6'b011000;
  localparam logic [5:0] OP_VLOAD    = 6'b111001;
  localparam logic [5:0] OP_VSTORE   = 6'b111000;
  localparam logic [5:0] OP_BEQ      = 6'b001100;
  localparam logic [5:0] OP_BGT      = 6'b001101;
  localparam logic [5:0] OP_JUMP     = 6'b000100;

  localparam logic [4:0] PC_ALIAS    = 5'b11111;

  logic       jumpPc_s;
  logic       pcSrc_s;
  logic       regWrite_s;
  logic       regWriteV_s;
  logic       memtoReg_s;
  logic       memWrite_s;
  logic       memSrc_s;
  logic       memData_s;
  logic       memDataV_s;
  logic       vecData_s;
  logic [1:0] instrSel_s;
  logic [2:0] aluControl_s;
  logic       branch_s;
  logic       aluSrc_s;
  logic [1:0] regSrc_s;
  logic [1:0] immSrc_s;
  logic       aluOp_s;

  // Opcode decode; every control starts at 0 so unlisted opcodes act as NOP.
  // Func is only read in the two R-type arms, which keeps an undriven Func
  // on other instructions away from ALUControl.
  always_comb begin
    jumpPc_s     = 1'b0;
    regWrite_s   = 1'b0;
    regWriteV_s  = 1'b0;
    memtoReg_s   = 1'b0;
    memWrite_s   = 1'b0;
    memSrc_s     = 1'b0;
    memData_s    = 1'b0;
    memDataV_s   = 1'b0;
    vecData_s    = 1'b0;
    instrSel_s   = 2'b00;
    aluControl_s = 3'b000;
    branch_s     = 1'b0;
    aluSrc_s     = 1'b0;
    regSrc_s     = 2'b00;
    immSrc_s     = 2'b00;
    aluOp_s      = 1'b0;
    case (Opcode)
      OP_SCALAR_R: begin
        regWrite_s   = 1'b1;
        aluControl_s = Func;
        instrSel_s   = 2'b00;
        regSrc_s     = 2'b00;
      end
      OP_VECTOR_R: begin
        regWriteV_s  = 1'b1;
        vecData_s    = 1'b1;
        aluControl_s = Func;
        instrSel_s   = 2'b01;
        regSrc_s     = 2'b01;
      end
      OP_ADDI: begin
        regWrite_s   = 1'b1;
        aluSrc_s     = 1'b1;
        immSrc_s     = 2'b00;
        aluControl_s = 3'b000;
        instrSel_s   = 2'b00;
      end
      OP_LOAD: begin
        regWrite_s   = 1'b1;
        memtoReg_s   = 1'b1;
        memData_s    = 1'b1;
        aluSrc_s     = 1'b1;
        immSrc_s     = 2'b01;
        aluControl_s = 3'b000;
        instrSel_s   = 2'b10;
      end
      OP_STORE: begin
        memWrite_s   = 1'b1;
        memSrc_s     = 1'b0;
        memData_s    = 1'b1;
        aluSrc_s     = 1'b1;
        immSrc_s     = 2'b01;
        regSrc_s     = 2'b10;
        instrSel_s   = 2'b10;
      end
      OP_VLOAD: begin
        regWriteV_s  = 1'b1;
        memtoReg_s   = 1'b1;
        memDataV_s   = 1'b1;
        vecData_s    = 1'b1;
        aluSrc_s     = 1'b1;
        immSrc_s     = 2'b01;
        instrSel_s   = 2'b10;
      end
      OP_VSTORE: begin
        memWrite_s   = 1'b1;
        memSrc_s     = 1'b1;
        memDataV_s   = 1'b1;
        vecData_s    = 1'b1;
        aluSrc_s     = 1'b1;
        immSrc_s     = 2'b01;
        regSrc_s     = 2'b11;
        instrSel_s   = 2'b10;
      end
      OP_BEQ, OP_BGT: begin
        branch_s     = 1'b1;
        aluOp_s      = 1'b1;
        aluControl_s = 3'b001;
        immSrc_s     = 2'b10;
        instrSel_s   = 2'b11;
      end
      OP_JUMP: begin
        branch_s     = 1'b1;
        jumpPc_s     = 1'b1;
        aluOp_s      = 1'b0;
        immSrc_s     = 2'b11;
        instrSel_s   = 2'b11;
      end
      default: begin
        jumpPc_s     = 1'b0;
      end
    endcase
  end

  // A scalar write to r31 is a write to the PC alias, so it redirects fetch
  // just like a jump does.
  always_comb begin
    pcSrc_s = jumpPc_s | (regWrite_s & (Rd == PC_ALIAS));
  end

  // Output register feeding the decode/execute pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PCSrc      <= 1'b0;
      RegWrite   <= 1'b0;
      RegWriteV  <= 1'b0;
      MemtoReg   <= 1'b0;
      MemWrite   <= 1'b0;
      MemSrc     <= 1'b0;
      MemData    <= 1'b0;
      MemDataV   <= 1'b0;
      VecData    <= 1'b0;
      InstrSel   <= 2'b00;
      ALUControl <= 3'b000;
      Branch     <= 1'b0;
      ALUSrc     <= 1'b0;
      RegSrc     <= 2'b00;
      ImmSrc     <= 2'b00;
      ALUOp      <= 1'b0;
    end else begin
      PCSrc      <= pcSrc_s;
      RegWrite   <= regWrite_s;
      RegWriteV  <= regWriteV_s;
      MemtoReg   <= memtoReg_s;
      MemWrite   <= memWrite_s;
      MemSrc     <= memSrc_s;
      MemData    <= memData_s;
      MemDataV   <= memDataV_s;
      VecData    <= vecData_s;
      InstrSel   <= instrSel_s;
      ALUControl <= aluControl_s;
      Branch     <= branch_s;
      ALUSrc     <= aluSrc_s;
      RegSrc     <= regSrc_s;
      ImmSrc     <= immSrc_s;
      ALUOp      <= aluOp_s;
    end
  end

endmodule

// File: tb/tb_simd_control_unit.sv
// ---------------------------------------------------------------------------
// tb_simd_control_unit
//   Self-checking bench for simd_control_unit. Inputs are driven on the
//   falling edge, outputs are sampled 1 time unit after the rising edge and
//   compared with a behavioural model that describes each instruction by its
//   class (load/store/vector/branch...) rather than by opcode arms.
// ---------------------------------------------------------------------------
module tb_simd_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic [2:0] Func;
  logic [4:0] Rd;
  logic       PCSrc, RegWrite, RegWriteV, MemtoReg, MemWrite, MemSrc;
  logic       MemData, MemDataV, VecData, Branch, ALUSrc, ALUOp;
  logic [1:0] InstrSel, RegSrc, ImmSrc;
  logic [2:0] ALUControl;

  int checkCount = 0;
  int failCount  = 0;

  simd_control_unit dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Func(Func), .Rd(Rd),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .RegWriteV(RegWriteV),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemSrc(MemSrc),
    .MemData(MemData), .MemDataV(MemDataV), .VecData(VecData),
    .InstrSel(InstrSel), .ALUControl(ALUControl), .Branch(Branch),
    .ALUSrc(ALUSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUOp(ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order:
  // {PCSrc,RegWrite,RegWriteV,MemtoReg,MemWrite,MemSrc,MemData,MemDataV,
  //  VecData,InstrSel[1:0],ALUControl[2:0],Branch,ALUSrc,RegSrc[1:0],
  //  ImmSrc[1:0],ALUOp}
  function automatic logic [20:0] observed();
    return {PCSrc, RegWrite, RegWriteV, MemtoReg, MemWrite, MemSrc, MemData,
            MemDataV, VecData, InstrSel, ALUControl, Branch, ALUSrc, RegSrc,
            ImmSrc, ALUOp};
  endfunction

  // Reference model: classify the instruction, then derive each control
  // from the classes it belongs to.
  function automatic logic [20:0] refModel(input logic [5:0] op,
                                           input logic [2:0] fn,
                                           input logic [4:0] rd);
    bit sR, vR, addi, ld, st, vld, vst, br, jmp, isR, isMem;
    bit pc, rw, rwv, m2r, mw, msrc, md, mdv, vd, bra, asrc, aop;
    logic [1:0] isel, rsrc, imm;
    logic [2:0] actl;
    sR   = (op == 6'd0);
    vR   = (op == 6'd32);
    addi = (op == 6'd8);
    ld   = (op == 6'd25);
    st   = (op == 6'd24);
    vld  = (op == 6'd57);
    vst  = (op == 6'd56);
    br   = (op == 6'd12) || (op == 6'd13);
    jmp  = (op == 6'd4);
    isR   = sR || vR;
    isMem = ld || st || vld || vst;
    rw   = sR || addi || ld;
    rwv  = vR || vld;
    m2r  = ld || vld;
    mw   = st || vst;
    msrc = vst;
    md   = ld || st;
    mdv  = vld || vst;
    vd   = vR || vld || vst;
    bra  = br || jmp;
    asrc = addi || isMem;
    aop  = br;
    pc   = jmp || (rw && rd == 5'd31);
    if (vR)               isel = 2'd1;
    else if (isMem)       isel = 2'd2;
    else if (br || jmp)   isel = 2'd3;
    else                  isel = 2'd0;
    if (isR)              actl = fn;
    else if (br)          actl = 3'd1;
    else                  actl = 3'd0;
    if (vR)               rsrc = 2'd1;
    else if (st)          rsrc = 2'd2;
    else if (vst)         rsrc = 2'd3;
    else                  rsrc = 2'd0;
    if (isMem)            imm = 2'd1;
    else if (br)          imm = 2'd2;
    else if (jmp)         imm = 2'd3;
    else                  imm = 2'd0;
    return {pc, rw, rwv, m2r, mw, msrc, md, mdv, vd, isel, actl, bra, asrc,
            rsrc, imm, aop};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one instruction for one rising edge and check the registered word.
  task automatic step(input string tag, input logic rstIn,
                      input logic [5:0] op, input logic [2:0] fn,
                      input logic [4:0] rd);
    logic [20:0] exp;
    @(negedge clk);
    rst_n  = rstIn;
    Opcode = op;
    Func   = fn;
    Rd     = rd;
    exp    = rstIn ? refModel(op, fn, rd) : 21'd0;
    @(posedge clk);
    #1;
    checkVal(tag, {11'd0, observed()}, {11'd0, exp});
  endtask

  logic [5:0] opList [10];

  initial begin
    opList = '{6'd0, 6'd32, 6'd8, 6'd25, 6'd24, 6'd57, 6'd56, 6'd12, 6'd13, 6'd4};
    rst_n  = 1'b0;
    Opcode = 6'b000000;
    Func   = 3'b000;
    Rd     = 5'b00000;

    // Reset held for two edges, then release.
    step("reset0", 1'b0, 6'b000000, 3'b000, 5'b00001);
    step("reset1", 1'b0, 6'b000000, 3'b000, 5'b00001);
    step("scalarR", 1'b1, 6'b000000, 3'b000, 5'b00001);
    checkVal("scalarR.RegWrite", {31'd0, RegWrite}, 32'd1);
    step("vectorR", 1'b1, 6'b100000, 3'b001, 5'b00010);
    checkVal("vectorR.ALUControl", {29'd0, ALUControl}, 32'd1);
    checkVal("vectorR.RegWrite", {31'd0, RegWrite}, 32'd0);
    step("addiFuncX", 1'b1, 6'b001000, 3'bxxx, 5'b00011);
    checkVal("addiFuncX.unknown", {31'd0, $isunknown(observed())}, 32'd0);
    step("load", 1'b1, 6'b011001, 3'b101, 5'b00100);
    step("store", 1'b1, 6'b011000, 3'b110, 5'b00101);
    checkVal("store.MemSrc", {31'd0, MemSrc}, 32'd0);
    step("vstore", 1'b1, 6'b111000, 3'b011, 5'b00110);
    checkVal("vstore.MemSrc", {31'd0, MemSrc}, 32'd1);
    step("vload", 1'b1, 6'b111001, 3'b111, 5'b00111);
    step("beq", 1'b1, 6'b001100, 3'b010, 5'b11111);
    checkVal("beq.PCSrc", {31'd0, PCSrc}, 32'd0);
    step("bgt", 1'b1, 6'b001101, 3'b100, 5'b01000);
    step("jump", 1'b1, 6'b000100, 3'b111, 5'b00000);
    checkVal("jump.PCSrc", {31'd0, PCSrc}, 32'd1);
    step("pcAlias", 1'b1, 6'b000000, 3'b010, 5'b11111);
    checkVal("pcAlias.PCSrc", {31'd0, PCSrc}, 32'd1);
    step("loadPcAlias", 1'b1, 6'b011001, 3'b000, 5'b11111);
    step("vecRd31", 1'b1, 6'b100000, 3'b000, 5'b11111);
    step("nop", 1'b1, 6'b111111, 3'b111, 5'b11111);
    step("preMidReset", 1'b1, 6'b111000, 3'b000, 5'b00001);
    step("midReset", 1'b0, 6'b011001, 3'b000, 5'b11111);
    step("postReset", 1'b1, 6'b001101, 3'b000, 5'b00001);

    // Randomized stream: mostly defined opcodes, some arbitrary ones,
    // occasional reset pulses and frequent PC-alias destinations.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic [4:0] rd;
      logic       rs;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else                           op = opList[$urandom_range(0, 9)];
      rd = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
      rs = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      step("random", rs, op, 3'($urandom), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
